// File: rtl/button_debouncer_pkg.sv
// Shared constants, debounce state type and counter sizing for the
// multi-channel button debouncer.
package button_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CLK_CNT = 65536;
    localparam int DEFAULT_SYNC_STAGES      = 2;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } db_state_e;

    // Counter width for a count limit n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: synchroniser, polarity fix, symmetric debounce FSM with
// registered edge pulses, and an optional long-press hold counter.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CLK_CNT   = DEFAULT_DEBOUNCE_CLK_CNT,
    parameter int LONG_PRESS_CLK_CNT = 0,
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter int ACTIVE_LOW         = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_debounced,
    output logic pressed,
    output logic released,
    output logic long_press
);
    localparam int CW = cnt_width(DEBOUNCE_CLK_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLK_CNT - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sample_q, sample_d;
    db_state_e              st_q, st_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], btn_raw};
        sample_d   = sync_q[SYNC_STAGES-1] ^ (ACTIVE_LOW != 0);
        st_d       = st_q;
        cnt_d      = cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (sample_q == (st_q == ST_PRESSED)) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // The full run of disagreeing samples has been seen: accept it.
            cnt_d      = '0;
            st_d       = sample_q ? ST_PRESSED : ST_RELEASED;
            pressed_d  = sample_q;
            released_d = ~sample_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= SYNC_IDLE;
            sample_q   <= 1'b0;
            st_q       <= ST_RELEASED;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sample_q   <= sample_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign btn_debounced = (st_q == ST_PRESSED);
    assign pressed       = pressed_q;
    assign released      = released_q;

    if (LONG_PRESS_CLK_CNT > 0) begin : g_long
        localparam int HW = cnt_width(LONG_PRESS_CLK_CNT + 1);
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CLK_CNT - 1);
        localparam logic [HW-1:0] HOLD_FULL = HW'(LONG_PRESS_CLK_CNT);

        logic [HW-1:0] hold_q, hold_d;
        logic          lp_q, lp_d;

        // Counting stops at HOLD_FULL, so one press can fire at most once;
        // a release landing on the completing cycle suppresses the pulse.
        always_comb begin
            hold_d = hold_q;
            lp_d   = 1'b0;
            if (pressed_d) begin
                hold_d = '0;
            end else if (st_q == ST_PRESSED && hold_q < HOLD_FULL) begin
                hold_d = hold_q + 1'b1;
                lp_d   = (hold_q == HOLD_LAST) && (st_d == ST_PRESSED);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_q <= '0;
                lp_q   <= 1'b0;
            end else begin
                hold_q <= hold_d;
                lp_q   <= lp_d;
            end
        end

        assign long_press = lp_q;
    end else begin : g_no_long
        assign long_press = 1'b0;
    end

endmodule

// File: rtl/button_debouncer_multi.sv
// Multi-channel button debouncer: CHANNELS independent lanes, each producing a
// debounced level plus pressed / released / long-press pulses.
module button_debouncer_multi
    import button_debouncer_pkg::*;
#(
    parameter int CHANNELS           = 4,
    parameter int DEBOUNCE_CLK_CNT   = DEFAULT_DEBOUNCE_CLK_CNT,
    parameter int LONG_PRESS_CLK_CNT = 0,
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter int ACTIVE_LOW         = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_debounced,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press
);
    if (CHANNELS < 1) begin : g_bad_channels
        $error("button_debouncer_multi: CHANNELS must be >= 1");
    end
    if (DEBOUNCE_CLK_CNT < 1) begin : g_bad_debounce
        $error("button_debouncer_multi: DEBOUNCE_CLK_CNT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debouncer_multi: SYNC_STAGES must be >= 2");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CLK_CNT  (DEBOUNCE_CLK_CNT),
            .LONG_PRESS_CLK_CNT(LONG_PRESS_CLK_CNT),
            .SYNC_STAGES       (SYNC_STAGES),
            .ACTIVE_LOW        (ACTIVE_LOW)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .btn_raw      (btn_in[gi]),
            .btn_debounced(btn_debounced[gi]),
            .pressed      (pressed[gi]),
            .released     (released[gi]),
            .long_press   (long_press[gi])
        );
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Self-checking bench: scenario tasks plus randomized traffic compared against a
// sliding-window reference model of the debouncer behaviour.
module tb_button_debouncer_multi;
    localparam int CH  = 4;
    localparam int D   = 8;
    localparam int L   = 32;
    localparam int NS  = 2;
    localparam int LAT = NS + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] btn_in, btn_al;
    logic [CH-1:0] db, pr, rl, lp;
    logic [CH-1:0] db_al, pr_al, rl_al, lp_al;

    int cmp_count  = 0;
    int fail_count = 0;
    int e;

    always #5 clk = ~clk;

    button_debouncer_multi #(
        .CHANNELS(CH), .DEBOUNCE_CLK_CNT(D), .LONG_PRESS_CLK_CNT(L),
        .SYNC_STAGES(NS), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset_n), .btn_in(btn_in),
        .btn_debounced(db), .pressed(pr), .released(rl), .long_press(lp)
    );

    button_debouncer_multi #(
        .CHANNELS(CH), .DEBOUNCE_CLK_CNT(1), .LONG_PRESS_CLK_CNT(0),
        .SYNC_STAGES(NS), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset(reset_n), .btn_in(btn_al),
        .btn_debounced(db_al), .pressed(pr_al), .released(rl_al), .long_press(lp_al)
    );

    // Reference model: sample at edge e is the raw level from edge e-LAT; the
    // level flips when the last D samples all disagree with it.
    logic [CH-1:0] raw_hist[$];
    logic [CH-1:0] s_hist[$];
    logic [CH-1:0] m_st, m_pr, m_rl, m_lp;
    logic [CH-1:0] armed;
    int            press_edge[CH];

    function automatic void model_reset();
        raw_hist.delete();
        s_hist.delete();
        m_st = '0; m_pr = '0; m_rl = '0; m_lp = '0; armed = '0;
        for (int c = 0; c < CH; c++) press_edge[c] = 0;
        e = 0;
    endfunction

    function automatic void model_step();
        logic [CH-1:0] s;
        logic          flip;
        if (!reset_n) return;
        raw_hist.push_back(btn_in);
        if (raw_hist.size() > LAT + 1) void'(raw_hist.pop_front());
        s = (raw_hist.size() == LAT + 1) ? raw_hist[0] : '0;
        s_hist.push_back(s);
        if (s_hist.size() > D) void'(s_hist.pop_front());
        m_pr = '0; m_rl = '0; m_lp = '0;
        for (int c = 0; c < CH; c++) begin
            flip = (s_hist.size() == D);
            for (int k = 0; k < s_hist.size(); k++)
                if (s_hist[k][c] == m_st[c]) flip = 1'b0;
            if (flip) begin
                m_st[c] = ~m_st[c];
                if (m_st[c]) begin
                    m_pr[c] = 1'b1; press_edge[c] = e; armed[c] = 1'b1;
                end else begin
                    m_rl[c] = 1'b1; armed[c] = 1'b0;
                end
            end
            if (armed[c] && m_st[c] && (e - press_edge[c] == L)) begin
                m_lp[c] = 1'b1; armed[c] = 1'b0;
            end
        end
    endfunction

    function automatic logic [4*CH-1:0] model_vec();
        return {m_st, m_pr, m_rl, m_lp};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        e++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*CH-1:0] obs;
        do_reset();
        btn_in = '1;
        for (int n = 0; n < D + LAT + 1; n++) begin
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL reset_prefill edge %0d: got %h want %h", e - 1, obs, model_vec());
            end
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        btn_in = CH'($urandom);
        #1;
        cmp_count++;
        if ({db, pr, rl, lp} !== '0) begin
            fail_count++;
            $display("FAIL reset_async: got %h want 0", {db, pr, rl, lp});
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            cmp_count++;
            if ({db, pr, rl, lp, db_al, pr_al, rl_al, lp_al} !== '0) begin
                fail_count++;
                $display("FAIL reset_hold cycle %0d: got %h want 0", n,
                         {db, pr, rl, lp, db_al, pr_al, rl_al, lp_al});
            end
            btn_in = CH'($urandom);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [4*CH-1:0] obs;
        int k;
        do_reset();
        btn_in = 4'b0001;
        for (int n = 0; n < 15; n++) begin
            k = e;
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL clean_model edge %0d: got %h want %h", k, obs, model_vec());
            end
            cmp_count++;
            if (pr !== ((k == 10) ? 4'b0001 : 4'b0000) || db !== ((k >= 10) ? 4'b0001 : 4'b0000)) begin
                fail_count++;
                $display("FAIL clean_press edge %0d: got pr=%b db=%b want pr=%b db=%b", k, pr, db,
                         (k == 10) ? 4'b0001 : 4'b0000, (k >= 10) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4*CH-1:0] obs;
        logic lvl;
        int   run, t_last, k;
        do_reset();
        btn_in = '0;
        lvl = 1'b1;
        while (!(e >= 100 && lvl == 1'b1)) begin
            run = $urandom_range(7, 1);
            btn_in[1] = lvl;
            repeat (run) begin
                k = e;
                cycle();
                obs = {db, pr, rl, lp};
                cmp_count++;
                if (obs !== model_vec()) begin
                    fail_count++;
                    $display("FAIL bounce_model edge %0d: got %h want %h", k, obs, model_vec());
                end
                cmp_count++;
                if (obs !== '0) begin
                    fail_count++;
                    $display("FAIL bounce_quiet edge %0d: got %h want 0", k, obs);
                end
            end
            lvl = ~lvl;
        end
        t_last = e;
        btn_in[1] = 1'b1;
        for (int n = 0; n < 15; n++) begin
            k = e;
            cycle();
            cmp_count++;
            if (pr[1] !== (k == t_last + 10)) begin
                fail_count++;
                $display("FAIL bounce_settle edge %0d (toggle %0d): got pr1=%b want %b",
                         k, t_last, pr[1], (k == t_last + 10));
            end
        end
    endtask

    task automatic test_long_press();
        logic [4*CH-1:0] obs;
        int k, a;
        do_reset();
        btn_in = 4'b0100;
        for (int n = 0; n < 80; n++) begin
            k = e;
            if (k == 61) btn_in[2] = 1'b0;
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL long_model edge %0d: got %h want %h", k, obs, model_vec());
            end
            cmp_count++;
            if (lp[2] !== (k == 42) || pr[2] !== (k == 10) || rl[2] !== (k == 71)) begin
                fail_count++;
                $display("FAIL long_press edge %0d: got lp=%b pr=%b rl=%b want %b %b %b", k,
                         lp[2], pr[2], rl[2], (k == 42), (k == 10), (k == 71));
            end
        end
        // Holds ending one cycle short of, and exactly at, the long-press point.
        for (int hold = L - 1; hold <= L; hold++) begin
            a = e;
            btn_in[2] = 1'b1;
            for (int n = 0; n < hold + 25; n++) begin
                k = e;
                if (k == a + hold) btn_in[2] = 1'b0;
                cycle();
                obs = {db, pr, rl, lp};
                cmp_count++;
                if (obs !== model_vec()) begin
                    fail_count++;
                    $display("FAIL short_model hold %0d edge %0d: got %h want %h", hold, k, obs, model_vec());
                end
                cmp_count++;
                if (lp[2] !== 1'b0 || rl[2] !== (k == a + hold + 10)) begin
                    fail_count++;
                    $display("FAIL short_hold %0d edge %0d: got lp=%b rl=%b want 0 %b", hold, k,
                             lp[2], rl[2], (k == a + hold + 10));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4*CH-1:0] obs;
        int k;
        do_reset();
        btn_in = 4'b1001;
        for (int n = 0; n < 13; n++) begin
            k = e;
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL simul_model edge %0d: got %h want %h", k, obs, model_vec());
            end
            cmp_count++;
            if (pr !== ((k == 10) ? 4'b1001 : 4'b0000)) begin
                fail_count++;
                $display("FAIL simul_press edge %0d: got %b want %b", k, pr, (k == 10) ? 4'b1001 : 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [4*CH-1:0] obs;
        int k;
        do_reset();
        btn_in = 4'b1001;
        repeat (6) cycle();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 13; n++) begin
            k = e;
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL midreset_model edge %0d: got %h want %h", k, obs, model_vec());
            end
            cmp_count++;
            if (pr !== ((k == 10) ? 4'b1001 : 4'b0000)) begin
                fail_count++;
                $display("FAIL midreset_press edge %0d after release: got %b want %b", k, pr,
                         (k == 10) ? 4'b1001 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        logic [4*CH-1:0] obs;
        int left[CH];
        int k;
        do_reset();
        for (int c = 0; c < CH; c++) left[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (left[c] == 0) begin
                    btn_in[c] = 1'($urandom_range(1, 0));
                    left[c] = ($urandom_range(3, 0) == 0) ? $urandom_range(60, 30) : $urandom_range(12, 1);
                end
                left[c]--;
            end
            k = e;
            cycle();
            obs = {db, pr, rl, lp};
            cmp_count++;
            if (obs !== model_vec()) begin
                fail_count++;
                $display("FAIL random_model edge %0d: got %h want %h", k, obs, model_vec());
            end
            cmp_count++;
            if ((pr & rl) !== '0) begin
                fail_count++;
                $display("FAIL random_exclusive edge %0d: got pr&rl=%b want 0", k, pr & rl);
            end
        end
    endtask

    task automatic test_active_low();
        logic [CH-1:0] al_hist[$];
        logic [CH-1:0] exp_db, prev_db;
        int t0, k;
        btn_al = '1;
        do_reset();
        prev_db = '0;
        t0 = -100;
        for (int n = 0; n < 50; n++) begin
            if (n == 10) begin
                btn_al[1] = 1'b0;
                t0 = e;
            end
            if (n >= 20) btn_al = CH'($urandom);
            al_hist.push_back(btn_al);
            k = e;
            cycle();
            exp_db = (al_hist.size() >= LAT + 1) ? ~al_hist[al_hist.size() - (LAT + 1)] : '0;
            cmp_count++;
            if ({db_al, pr_al, rl_al, lp_al} !== {exp_db, exp_db & ~prev_db, ~exp_db & prev_db, 4'b0000}) begin
                fail_count++;
                $display("FAIL active_low edge %0d: got %h want %h", k, {db_al, pr_al, rl_al, lp_al},
                         {exp_db, exp_db & ~prev_db, ~exp_db & prev_db, 4'b0000});
            end
            if (k == t0 + 3) begin
                cmp_count++;
                if (pr_al !== 4'b0010) begin
                    fail_count++;
                    $display("FAIL active_low_press edge %0d: got %b want 0010", k, pr_al);
                end
            end
            prev_db = exp_db;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_in  = '0;
        btn_al  = '1;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        test_active_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
